// File: rtl/ifid_hazard.sv
// IF/ID pipeline register with load-use hazard detection, flush control and
// saturating stall/flush event counters.
module ifid_hazard (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        pc_write,
  output logic        idex_flush,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] ifid_pc_r;
  logic [31:0] ifid_instr_r;
  logic        ifid_valid_r;
  logic [15:0] stall_count_r;
  logic [15:0] flush_count_r;

  logic        hazard_s;
  logic        do_flush_s;
  logic        do_stall_s;
  logic        pc_write_s;
  logic        idex_flush_s;

  assign ifid_pc     = ifid_pc_r;
  assign ifid_instr  = ifid_instr_r;
  assign ifid_valid  = ifid_valid_r;
  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;

  assign rs = ifid_instr_r[25:21];
  assign rt = ifid_instr_r[20:16];
  assign rd = ifid_instr_r[15:11];

  // The rt comparison is deliberately conservative: it applies even to opcodes that never read rt.
  assign hazard_s = (state_r == RUN) && ifid_valid_r && idex_memread &&
                    (idex_rt != 5'd0) && ((idex_rt == rs) || (idex_rt == rt));

  // Next-state and per-cycle action selection, strict priority branch > jump > hazard > load.
  always_comb begin
    state_nxt_s  = RUN;
    do_flush_s   = 1'b0;
    do_stall_s   = 1'b0;
    pc_write_s   = imem_ready;
    idex_flush_s = 1'b0;
    case (state_r)
      RUN, HOLD: begin
        if (branch_taken) begin
          do_flush_s   = 1'b1;
          pc_write_s   = 1'b1;
          idex_flush_s = 1'b1;
        end else if (jump) begin
          do_flush_s   = 1'b1;
          pc_write_s   = 1'b1;
        end else if (hazard_s) begin
          do_stall_s   = 1'b1;
          pc_write_s   = 1'b0;
          idex_flush_s = 1'b1;
          state_nxt_s  = HOLD;
        end else if (state_r == HOLD) begin
          pc_write_s   = 1'b1;
        end else begin
          pc_write_s   = imem_ready;
        end
      end
      default: begin
        state_nxt_s  = RUN;
        pc_write_s   = 1'b1;
        idex_flush_s = 1'b0;
      end
    endcase
  end

  // Reset overrides the fetch/flush controls immediately, without waiting for a clock.
  always_comb begin
    pc_write   = 1'b1;
    idex_flush = 1'b0;
    if (reset) begin
      pc_write   = 1'b1;
      idex_flush = 1'b0;
    end else begin
      pc_write   = pc_write_s;
      idex_flush = idex_flush_s;
    end
  end

  // FSM state and IF/ID pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= RUN;
      ifid_pc_r    <= 32'd0;
      ifid_instr_r <= 32'd0;
      ifid_valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (do_flush_s) begin
        ifid_pc_r    <= 32'd0;
        ifid_instr_r <= 32'd0;
        ifid_valid_r <= 1'b0;
      end else if (do_stall_s) begin
        ifid_pc_r    <= ifid_pc_r;
        ifid_instr_r <= ifid_instr_r;
        ifid_valid_r <= ifid_valid_r;
      end else if (imem_ready) begin
        ifid_pc_r    <= pc_plus4;
        ifid_instr_r <= instr;
        ifid_valid_r <= 1'b1;
      end else begin
        ifid_instr_r <= 32'd0;
        ifid_valid_r <= 1'b0;
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_r <= 16'd0;
      flush_count_r <= 16'd0;
    end else begin
      if (do_stall_s && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'd1;
      end else begin
        stall_count_r <= stall_count_r;
      end
      if (do_flush_s && (flush_count_r != 16'hFFFF)) begin
        flush_count_r <= flush_count_r + 16'd1;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

endmodule

// File: tb/tb_ifid_hazard.sv
// Table-driven, scoreboarded bench for ifid_hazard plus hand sequences for
// async reset during HOLD and counter saturation.
module tb_ifid_hazard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_plus4 = 32'd0;
  logic [31:0] instr = 32'd0;
  logic        imem_ready = 1'b0;
  logic        jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic        idex_memread = 1'b0;
  logic [4:0]  idex_rt = 5'd0;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        pc_write;
  logic        idex_flush;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] I1 = 32'h012A4020; // rs=9 rt=10 rd=8
  localparam logic [31:0] I2 = 32'h00642820; // rs=3 rt=4  rd=5

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] ins;
    logic        rdy;
    logic        jmp;
    logic        br;
    logic        mr;
    logic [4:0]  irt;
    logic        e_pw;
    logic        e_fl;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_v;
    logic [15:0] e_s;
    logic [15:0] e_f;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[24];

  ifid_hazard dut (
    .clk(clk), .reset(reset), .pc_plus4(pc_plus4), .instr(instr),
    .imem_ready(imem_ready), .jump(jump), .branch_taken(branch_taken),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
    .rs(rs), .rt(rt), .rd(rd), .pc_write(pc_write), .idex_flush(idex_flush),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic [31:0] pc4, input logic [31:0] ins,
                              input logic rdy, input logic jmp, input logic br,
                              input logic mr, input logic [4:0] irt,
                              input logic e_pw, input logic e_fl,
                              input logic [31:0] e_pc, input logic [31:0] e_ins,
                              input logic e_v, input logic [15:0] e_s,
                              input logic [15:0] e_f);
    vec_t v;
    v.pc4 = pc4; v.ins = ins; v.rdy = rdy; v.jmp = jmp; v.br = br;
    v.mr = mr; v.irt = irt; v.e_pw = e_pw; v.e_fl = e_fl; v.e_pc = e_pc;
    v.e_ins = e_ins; v.e_v = e_v; v.e_s = e_s; v.e_f = e_f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    logic [31:0] ei;
    pc_plus4 = v.pc4; instr = v.ins; imem_ready = v.rdy; jump = v.jmp;
    branch_taken = v.br; idex_memread = v.mr; idex_rt = v.irt;
    #3;
    chk({tag, " pc_write"}, {31'd0, pc_write}, {31'd0, v.e_pw});
    chk({tag, " idex_flush"}, {31'd0, idex_flush}, {31'd0, v.e_fl});
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    ei = e.e_ins;
    chk({tag, " ifid_pc"}, ifid_pc, e.e_pc);
    chk({tag, " ifid_instr"}, ifid_instr, ei);
    chk({tag, " ifid_valid"}, {31'd0, ifid_valid}, {31'd0, e.e_v});
    chk({tag, " rs"}, {27'd0, rs}, {27'd0, ei[25:21]});
    chk({tag, " rt"}, {27'd0, rt}, {27'd0, ei[20:16]});
    chk({tag, " rd"}, {27'd0, rd}, {27'd0, ei[15:11]});
    chk({tag, " stall_count"}, {16'd0, stall_count}, {16'd0, e.e_s});
    chk({tag, " flush_count"}, {16'd0, flush_count}, {16'd0, e.e_f});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ifid_pc"}, ifid_pc, 32'd0);
    chk({tag, " ifid_instr"}, ifid_instr, 32'd0);
    chk({tag, " ifid_valid"}, {31'd0, ifid_valid}, 32'd0);
    chk({tag, " stall_count"}, {16'd0, stall_count}, 32'd0);
    chk({tag, " flush_count"}, {16'd0, flush_count}, 32'd0);
    chk({tag, " pc_write"}, {31'd0, pc_write}, 32'd1);
    chk({tag, " idex_flush"}, {31'd0, idex_flush}, 32'd0);
  endtask

  initial begin
    //            pc4     instr  rdy   jmp   br    mr    irt     pw    fl    e_pc    e_ins  v     stall     flush
    tbl[0]  = mk(32'd4,  I1,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 32'd4,  I1,    1'b1, 16'd0, 16'd0);
    tbl[1]  = mk(32'd8,  I2,    1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'd4,  32'd0, 1'b0, 16'd0, 16'd0);
    tbl[2]  = mk(32'd8,  32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 32'd8,  32'd0, 1'b1, 16'd0, 16'd0);
    tbl[3]  = mk(32'd12, I1,    1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 32'd12, I1,    1'b1, 16'd0, 16'd0);
    tbl[4]  = mk(32'd16, I2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 32'd12, I1,    1'b1, 16'd1, 16'd0);
    tbl[5]  = mk(32'd16, I2,    1'b1, 1'b0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b0, 32'd16, I2,    1'b1, 16'd1, 16'd0);
    tbl[6]  = mk(32'd20, I1,    1'b1, 1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b1, 32'd16, I2,    1'b1, 16'd2, 16'd0);
    tbl[7]  = mk(32'd20, I2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd4,  1'b1, 1'b0, 32'd20, I2,    1'b1, 16'd2, 16'd0);
    tbl[8]  = mk(32'd24, I1,    1'b1, 1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b1, 32'd20, I2,    1'b1, 16'd3, 16'd0);
    tbl[9]  = mk(32'd24, I2,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 32'd24, I2,    1'b1, 16'd3, 16'd0);
    tbl[10] = mk(32'd28, I1,    1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  1'b1, 1'b1, 32'd0,  32'd0, 1'b0, 16'd3, 16'd1);
    tbl[11] = mk(32'd28, I1,    1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 32'd0,  32'd0, 1'b0, 16'd3, 16'd2);
    tbl[12] = mk(32'd28, I1,    1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 32'd0,  32'd0, 1'b0, 16'd3, 16'd3);
    tbl[13] = mk(32'd28, I1,    1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 32'd0,  32'd0, 1'b0, 16'd3, 16'd4);
    tbl[14] = mk(32'd32, I1,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 32'd32, I1,    1'b1, 16'd3, 16'd4);
    tbl[15] = mk(32'd36, I2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 32'd32, I1,    1'b1, 16'd4, 16'd4);
    tbl[16] = mk(32'd36, I2,    1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 32'd0,  32'd0, 1'b0, 16'd4, 16'd5);
    tbl[17] = mk(32'd40, I2,    1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 16'd4, 16'd5);
    tbl[18] = mk(32'd36, I1,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 32'd36, I1,    1'b1, 16'd4, 16'd5);
    tbl[19] = mk(32'd40, I2,    1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1, 32'd36, I1,    1'b1, 16'd5, 16'd5);
    tbl[20] = mk(32'd40, I2,    1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 32'd36, 32'd0, 1'b0, 16'd5, 16'd5);
    tbl[21] = mk(32'd40, I1,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 32'd40, I1,    1'b1, 16'd5, 16'd5);
    tbl[22] = mk(32'd44, I2,    1'b1, 1'b0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b0, 32'd44, I2,    1'b1, 16'd5, 16'd5);
    tbl[23] = mk(32'd48, I1,    1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 32'd0,  32'd0, 1'b0, 16'd5, 16'd6);

    // Reset with hostile inputs: flush/fetch controls must still show reset values.
    imem_ready = 1'b0; branch_taken = 1'b1; idex_memread = 1'b1; idex_rt = 5'd9;
    #1 reset = 1'b1;
    #1 chk_reset_vals("reset_async");
    @(posedge clk);
    #1 chk_reset_vals("reset_edge");
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Enter HOLD, then assert reset mid-cycle.
    apply(mk(32'd48, I1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'd48, I1, 1'b1, 16'd5, 16'd6), "pre_hold");
    apply(mk(32'd52, I2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 32'd48, I1, 1'b1, 16'd6, 16'd6), "hold_entry");
    #1 reset = 1'b1;
    #1 chk_reset_vals("reset_mid_hold");
    @(posedge clk);
    #1 chk_reset_vals("reset_mid_hold_edge");
    reset = 1'b0;
    apply(mk(32'd4, I1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'd4, I1, 1'b1, 16'd0, 16'd0), "post_reset_load");
    apply(mk(32'd8, I2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 32'd4, I1, 1'b1, 16'd1, 16'd0), "post_reset_stall");

    // Preload flushes up to 65533, then step through the saturation point.
    jump = 1'b1; branch_taken = 1'b0; idex_memread = 1'b0;
    for (int k = 0; k < 65533; k++) begin
      @(posedge clk);
      #1;
    end
    apply(mk(32'd8, I2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 16'd1, 16'hFFFE), "sat_fffe");
    for (int k = 0; k < 3; k++) begin
      apply(mk(32'd8, I2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 16'd1, 16'hFFFF),
            $sformatf("sat_ffff%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
